// File: rtl/note_recorder.sv
// Key-pattern recorder: captures the live 6-bit key vector as run-length events
// and replays them on other_sound, all paced by an internal tick divider.
module note_recorder #(
  parameter int DEPTH    = 64,
  parameter int TICK_DIV = 500000,
  parameter int DUR_W    = 16
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic [5:0]               user_input,
  input  logic                     record,
  input  logic                     play,
  input  logic                     stop,
  output logic [5:0]               other_sound,
  output logic                     recording,
  output logic                     playing,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   event_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;
  localparam logic [DUR_W-1:0] DUR_ONE = DUR_W'(1);

  typedef enum logic [1:0] {IDLE, REC, PLAY} state_t;

  typedef struct packed {
    logic [5:0]       vec;
    logic [DUR_W-1:0] dur;
  } event_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    tick_cnt;
  event_t           run;
  event_t           mem [DEPTH];
  logic [AW-1:0]    idx;
  logic [AW-1:0]    idx_inc;
  logic [DUR_W-1:0] remaining;

  logic tick, same, rec_stop, rec_split, wr_en, wr_last;
  logic start_rec, start_play, next_ok, play_end;
  logic [DUR_W-1:0] wr_dur;

  assign tick       = (state != IDLE) && (tick_cnt == TW'(TICK_DIV - 1));
  assign same       = (user_input == run.vec) && (run.dur != DUR_MAX);
  assign rec_stop   = (state == REC) && stop;
  assign rec_split  = (state == REC) && !stop && tick && !same;
  assign wr_en      = rec_stop || rec_split;
  assign wr_last    = (event_count == CW'(DEPTH - 1));
  // A stop landing on a merging tick still credits that tick to the final run.
  assign wr_dur     = (tick && same) ? run.dur + 1'b1 : run.dur;
  assign start_rec  = (state == IDLE) && record && !stop;
  assign start_play = (state == IDLE) && play && !record && !stop && (event_count != '0);
  assign idx_inc    = idx + 1'b1;
  assign next_ok    = ({1'b0, idx} + 1'b1) < event_count;
  assign play_end   = (state == PLAY) &&
                      (stop || (tick && (remaining <= DUR_ONE) && !next_ok));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of process ordering.
  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start_rec) state_nxt = REC;
            else if (start_play) state_nxt = PLAY;
      REC:  if (rec_stop || (rec_split && wr_last)) state_nxt = IDLE;
      PLAY: if (play_end) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    recording = (state == REC);
    playing   = (state == PLAY);
  end

  // NOTE: the event memory has no reset; event_count alone defines which
  // slots are valid, so stale contents are never observed.
  always_ff @(posedge clock) begin
    if (wr_en) mem[event_count[AW-1:0]] <= '{vec: run.vec, dur: wr_dur};
  end

  always_ff @(posedge clock or posedge resetn) begin
    if (resetn) begin
      tick_cnt    <= '0;
      run         <= '0;
      idx         <= '0;
      remaining   <= '0;
      other_sound <= '0;
      event_count <= '0;
      full        <= 1'b0;
    end else begin
      if (state == IDLE || tick) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 1'b1;

      if (start_rec) begin
        event_count <= '0;
        full        <= 1'b0;
        run         <= '{vec: user_input, dur: DUR_ONE};
      end

      if (state == REC) begin
        if (wr_en) begin
          event_count <= event_count + 1'b1;
          if (wr_last) full <= 1'b1;
        end
        if (rec_split)          run     <= '{vec: user_input, dur: DUR_ONE};
        else if (tick && same)  run.dur <= run.dur + 1'b1;
      end

      if (start_play) begin
        idx         <= '0;
        other_sound <= mem[0].vec;
        remaining   <= mem[0].dur;
      end

      if (state == PLAY) begin
        if (play_end) begin
          other_sound <= '0;
        end else if (tick) begin
          if (remaining > DUR_ONE) begin
            remaining <= remaining - 1'b1;
          end else begin
            idx         <= idx_inc;
            other_sound <= mem[idx_inc].vec;
            remaining   <= mem[idx_inc].dur;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder with a short tick (4 clocks), 4 slots and
// 3-bit durations so saturation and full conditions are reached quickly.
module tb_note_recorder;

  localparam int DEPTH    = 4;
  localparam int TICK_DIV = 4;
  localparam int DUR_W    = 3;

  logic       clock = 1'b0;
  logic       resetn;
  logic [5:0] user_input;
  logic       record, play, stop;
  logic [5:0] other_sound;
  logic       recording, playing, full;
  logic [$clog2(DEPTH):0] event_count;

  int n_checks = 0;
  int n_pass   = 0;

  note_recorder #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV), .DUR_W(DUR_W)) dut (
    .clock       (clock),
    .resetn      (resetn),
    .user_input  (user_input),
    .record      (record),
    .play        (play),
    .stop        (stop),
    .other_sound (other_sound),
    .recording   (recording),
    .playing     (playing),
    .full        (full),
    .event_count (event_count)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; the following posedge samples the strobes.
  task automatic pulse(input logic r, input logic p, input logic s);
    record = r; play = p; stop = s;
    @(negedge clock);
    record = 1'b0; play = 1'b0; stop = 1'b0;
  endtask

  // Entered at the negedge just after the play edge; walks the whole playback.
  task automatic check_playback(input logic [5:0] v0, input int c0,
                                input logic [5:0] v1, input int c1);
    for (int k = 0; k <= c0 + c1; k++) begin
      logic [5:0] e;
      e = (k < c0) ? v0 : (k < c0 + c1) ? v1 : 6'd0;
      check($sformatf("play_snd[%0d]", k), other_sound, e);
      if (k == c0 + c1) check("play_done", playing, 0);
      @(negedge clock);
    end
  endtask

  initial begin
    resetn = 1'b1; user_input = '0; record = 1'b0; play = 1'b0; stop = 1'b0;
    repeat (2) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    check("rst_sound", other_sound, 0);
    check("rst_rec",   recording, 0);
    check("rst_play",  playing, 0);
    check("rst_full",  full, 0);
    check("rst_count", event_count, 0);

    // play with no recording is ignored
    pulse(1'b0, 1'b1, 1'b0);
    check("empty_play",  playing, 0);
    check("empty_sound", other_sound, 0);

    // basic record: 000001 for 2 ticks, then 000100 for 4
    user_input = 6'b000001;
    pulse(1'b1, 1'b0, 1'b0);
    check("basic_rec",       recording, 1);
    check("basic_cnt_entry", event_count, 0);
    repeat (4) @(negedge clock);
    user_input = 6'b000100;
    repeat (16) @(negedge clock);
    pulse(1'b0, 1'b0, 1'b1);
    check("basic_rec_off", recording, 0);
    check("basic_count",   event_count, 2);
    check("basic_full",    full, 0);
    pulse(1'b0, 1'b1, 1'b0);
    check("basic_playing", playing, 1);
    check_playback(6'b000001, 8, 6'b000100, 16);
    check("basic_count_kept", event_count, 2);

    // saturation: 9 ticks of one key splits into {7},{3}
    user_input = 6'b000010;
    pulse(1'b1, 1'b0, 1'b0);
    repeat (36) @(negedge clock);
    pulse(1'b0, 1'b0, 1'b1);
    check("sat_count", event_count, 2);
    pulse(1'b0, 1'b1, 1'b0);
    check_playback(6'b000010, 28, 6'b000010, 12);

    // full: toggling every tick fills all 4 slots on the 4th tick
    user_input = 6'b000001;
    pulse(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      user_input = (i % 2 == 0) ? 6'b000010 : 6'b000001;
      repeat (4) @(negedge clock);
      if (i == 2) check("full_not_yet", recording, 1);
    end
    check("full_flag",  full, 1);
    check("full_count", event_count, 4);
    check("full_idle",  recording, 0);
    pulse(1'b0, 1'b0, 1'b1);
    check("full_stop_flag",  full, 1);
    check("full_stop_count", event_count, 4);
    check("full_stop_play",  playing, 0);

    // record+play together in IDLE -> record wins
    user_input = 6'b001000;
    pulse(1'b1, 1'b1, 1'b0);
    check("prio_rec",       recording, 1);
    check("prio_play",      playing, 0);
    check("prio_full_clr",  full, 0);
    check("prio_count_clr", event_count, 0);
    repeat (8) @(negedge clock);
    pulse(1'b0, 1'b0, 1'b1);
    check("prio_count", event_count, 1);

    // stop+record together in IDLE -> stays IDLE
    pulse(1'b1, 1'b0, 1'b1);
    check("stoprec_idle",  recording, 0);
    check("stoprec_count", event_count, 1);

    // record during PLAY is ignored; event {001000,3} plays 12 cycles
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b1, 1'b0, 1'b0);
    check("recplay_playing", playing, 1);
    check("recplay_rec",     recording, 0);
    check("recplay_sound",   other_sound, 6'b001000);
    repeat (10) @(negedge clock);
    check("recplay_last", other_sound, 6'b001000);
    @(negedge clock);
    check("recplay_end_sound", other_sound, 0);
    check("recplay_end_play",  playing, 0);
    check("recplay_count",     event_count, 1);

    // asynchronous reset in the middle of playback
    pulse(1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clock);
    check("arst_pre_play", playing, 1);
    #1 resetn = 1'b1;
    #1;
    check("arst_sound", other_sound, 0);
    check("arst_play",  playing, 0);
    check("arst_count", event_count, 0);
    @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    pulse(1'b0, 1'b1, 1'b0);
    check("arst_play_ignored", playing, 0);
    check("arst_sound_idle",   other_sound, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
